axi_burst_seq: RTL and testbench
================================

AXI_BURST_SEQ -- requirements
Module: axi_burst_seq

Parameters
REQ-001 SHALL provide `ADDR_WTH`, default 32, AXI address width.
REQ-002 SHALL provide `DATA_WTH`, default 64, AXI data width; a power of two, at least 8.
REQ-003 SHALL provide `LEN_WTH`, default 8, burst-length field width.
REQ-004 SHALL provide `ID_WTH`, default 4, AXI ID width; all IDs are driven to 0.

Interface
REQ-005 SHALL have ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: start request, sampled in IDLE only.
- `mode` in 2: 00 write only, 01 read only, 10 write then read, 11 treated as 10.
- `base_addr` in `ADDR_WTH`: first burst address.
- `num_bursts` in 16: bursts per phase; 0 means the phase is skipped.
- `burst_len` in `LEN_WTH`: awlen/arlen value; beats = `burst_len` + 1.
- `busy` out 1: high from start acceptance until done.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: error flag, sticky until the next start.
- `cycle_cnt` out 32: clocks from start acceptance to `done`.
- AXI master write address: `awid`, `awaddr`, `awlen`, `awvalid` out; `awready` in.
- AXI master write data: `wdata`, `wlast`, `wvalid` out; `wready` in.
- AXI master write response: `bid`, `bresp`, `bvalid` in; `bready` out.
- AXI master read address: `arid`, `araddr`, `arlen`, `arvalid` out; `arready` in.
- AXI master read data: `rid`, `rdata`, `rresp`, `rlast`, `rvalid` in; `rready` out.

Function
REQ-006 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, with exactly one burst outstanding at a time.
REQ-007 IDLE with `start`=1 SHALL do the following on that edge:
- latch `mode`, `base_addr`, `num_bursts` and `burst_len`;
- clear `err` and `cycle_cnt`;
- set `busy`;
- go to WR_ADDR if the write phase is selected and `num_bursts`≠0, else to RD_ADDR if the read phase is selected and `num_bursts`≠0, else to DONE.
REQ-008 In WR_ADDR:
- `awvalid`=1, `awaddr`=current address, `awlen`=latched `burst_len`;
- awvalid/awaddr/awlen SHALL stay stable until `awready`;
- on awvalid&awready, go to WR_DATA.
REQ-009 In WR_DATA:
- `wvalid`=1, `wdata` = zero-extended 32-bit pattern counter;
- `wlast`=1 on beat `burst_len` only;
- each wvalid&wready advances the beat and pattern counters;
- the last accepted beat goes to WR_RESP.
REQ-010 In WR_RESP:
- `bready`=1;
- on bvalid, `bresp`≠00 SHALL set `err`;
- then, if the burst count remains nonzero, go to WR_ADDR, else to RD_ADDR (read phase selected) or DONE.
REQ-011 After each completed burst, the address SHALL advance by (`burst_len`+1)·`DATA_WTH`/8, modulo 2^`ADDR_WTH` (wrap-around allowed, no boundary check).
REQ-012 Entering the read phase SHALL reload the address to latched `base_addr`, the burst count to `num_bursts`, and the pattern counter to 0.
REQ-013 The pattern counter SHALL also be 0 at start acceptance.
REQ-014 In RD_ADDR:
- `arvalid`=1, `araddr`=current address, `arlen`=`burst_len`;
- stable until `arready`;
- then go to RD_DATA.
REQ-015 In RD_DATA:
- `rready`=1;
- on each rvalid, compare `rdata` with the zero-extended pattern counter, and set `err` on mismatch or `rresp`≠00;
- advance the pattern counter;
- on rvalid&rlast, decrement the burst count and go to RD_ADDR or DONE.
REQ-016 `rlast` arriving early or late relative to `burst_len` SHALL set `err`; `rlast` alone terminates the burst.
REQ-017 DONE SHALL assert `done` for one cycle, clear `busy` and return to IDLE; `done` SHALL NOT assert in any other state.
REQ-018 `cycle_cnt` SHALL increment every cycle while `busy`=1, freeze at done, and saturate at 0xFFFFFFFF.
REQ-019 `start` while `busy` SHALL be ignored; latched configuration SHALL NOT change mid-run.
REQ-020 Valid/ready outputs SHALL be registered; no combinational path from any AXI ready/valid input to any AXI output.

Reset
REQ-021 `rst`=0 SHALL asynchronously force:
- state IDLE;
- `awvalid`, `wvalid`, `wlast`, `bready`, `arvalid`, `rready`, `busy`, `done`, `err` = 0;
- `cycle_cnt`, `awaddr`, `araddr`, `wdata`, `awlen`, `arlen` = 0.
REQ-022 Reset mid-burst SHALL abandon the transaction with no completion pulse; operation resumes only on a new `start` after deassertion.

Verification
REQ-023 Mode 00, base 0x1000, 2 bursts, len 3, `DATA_WTH` 64, always-ready slave, OKAY:
- awaddr 0x1000 then 0x1020;
- wdata 0..7 with wlast on beats 3 and 7;
- one `done`, `err`=0.
REQ-024 Mode 10, same configuration, slave returning the written data:
- reads at 0x1000 and 0x1020;
- rdata 0..7 matches, `err`=0;
- `cycle_cnt` equals the counted busy cycles.
REQ-025 Mode 01 with rdata beat 2 corrupted to 0xFF: `err`=1 at done and held until the next start.
REQ-026 Backpressure: awready/wready/arready low for 5 cycles each:
- addresses and wdata stable throughout;
- no beat lost or duplicated.
REQ-027 `num_bursts`=0 with `start`: `done` two cycles after start acceptance, no AXI valid asserted.
REQ-028 `rst` asserted during WR_DATA beat 1:
- all outputs 0 asynchronously, no `done`;
- the next `start` runs cleanly from `base_addr`.

Source files
------------

// File: rtl/axi_burst_seq.sv
// AXI burst traffic sequencer: writes an incrementing pattern in fixed-length
// bursts, then optionally reads the same region back and checks it.
module axi_burst_seq #(
  parameter int ADDR_WTH = 32,
  parameter int DATA_WTH = 64,
  parameter int LEN_WTH  = 8,
  parameter int ID_WTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_WTH-1:0] base_addr,
  input  logic [15:0]         num_bursts,
  input  logic [LEN_WTH-1:0]  burst_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         cycle_cnt,
  output logic [ID_WTH-1:0]   awid,
  output logic [ADDR_WTH-1:0] awaddr,
  output logic [LEN_WTH-1:0]  awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_WTH-1:0] wdata,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WTH-1:0]   bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_WTH-1:0]   arid,
  output logic [ADDR_WTH-1:0] araddr,
  output logic [LEN_WTH-1:0]  arlen,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WTH-1:0]   rid,
  input  logic [DATA_WTH-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  localparam int SH = $clog2(DATA_WTH/8);

  state_t               state;
  logic [1:0]           mode_q;
  logic [ADDR_WTH-1:0]  base_q, addr_q, addr_nxt;
  logic [15:0]          nb_q, bcnt_q, bcnt_nxt;
  logic [LEN_WTH-1:0]   len_q, beat_q;
  logic [31:0]          pat_q, pat_nxt;
  logic [DATA_WTH-1:0]  pat_ext;
  logic                 rd_sel;
  logic                 unused_ids;

  assign awid       = '0;
  assign arid       = '0;
  assign unused_ids = ^{bid, rid};

  // Bursts are contiguous: step by beats * bytes-per-beat, wrapping freely.
  assign addr_nxt = addr_q + ((ADDR_WTH'(len_q) + ADDR_WTH'(1)) << SH);
  assign bcnt_nxt = bcnt_q - 16'd1;
  assign pat_nxt  = pat_q + 32'd1;
  assign pat_ext  = DATA_WTH'(pat_q);
  assign rd_sel   = (mode_q != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mode_q <= '0; base_q <= '0; nb_q <= '0; len_q <= '0;
      addr_q <= '0; bcnt_q <= '0; beat_q <= '0; pat_q <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; cycle_cnt <= '0;
      awaddr <= '0; awlen <= '0; awvalid <= 1'b0;
      wdata <= '0; wlast <= 1'b0; wvalid <= 1'b0; bready <= 1'b0;
      araddr <= '0; arlen <= '0; arvalid <= 1'b0; rready <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
      case (state)
        IDLE: if (start) begin
          mode_q <= mode; base_q <= base_addr; nb_q <= num_bursts; len_q <= burst_len;
          addr_q <= base_addr; bcnt_q <= num_bursts; pat_q <= '0; beat_q <= '0;
          err <= 1'b0; cycle_cnt <= '0; busy <= 1'b1;
          awlen <= burst_len; arlen <= burst_len;
          if (num_bursts == 16'd0) state <= DONE;
          else if (mode != 2'b01) begin
            awaddr <= base_addr; awvalid <= 1'b1; state <= WR_ADDR;
          end else begin
            araddr <= base_addr; arvalid <= 1'b1; state <= RD_ADDR;
          end
        end
        WR_ADDR: if (awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          wdata   <= pat_ext;
          wlast   <= (len_q == '0);
          beat_q  <= '0;
          state   <= WR_DATA;
        end
        WR_DATA: if (wready) begin
          pat_q <= pat_nxt;
          if (wlast) begin
            wvalid <= 1'b0; wlast <= 1'b0; bready <= 1'b1; state <= WR_RESP;
          end else begin
            beat_q <= beat_q + LEN_WTH'(1);
            wdata  <= DATA_WTH'(pat_nxt);
            wlast  <= (beat_q + LEN_WTH'(1) == len_q);
          end
        end
        WR_RESP: if (bvalid) begin
          bready <= 1'b0;
          if (bresp != 2'b00) err <= 1'b1;
          bcnt_q <= bcnt_nxt;
          if (bcnt_nxt != 16'd0) begin
            addr_q <= addr_nxt; awaddr <= addr_nxt; awvalid <= 1'b1; state <= WR_ADDR;
          end else if (rd_sel) begin
            // read phase replays the same region and pattern from the start
            addr_q <= base_q; bcnt_q <= nb_q; pat_q <= '0;
            araddr <= base_q; arvalid <= 1'b1; state <= RD_ADDR;
          end else state <= DONE;
        end
        RD_ADDR: if (arready) begin
          arvalid <= 1'b0; rready <= 1'b1; beat_q <= '0; state <= RD_DATA;
        end
        RD_DATA: if (rvalid) begin
          if (rdata != pat_ext || rresp != 2'b00) err <= 1'b1;
          pat_q <= pat_nxt;
          if (rlast) begin
            if (beat_q != len_q) err <= 1'b1;
            rready <= 1'b0;
            bcnt_q <= bcnt_nxt;
            if (bcnt_nxt != 16'd0) begin
              addr_q <= addr_nxt; araddr <= addr_nxt; arvalid <= 1'b1; state <= RD_ADDR;
            end else state <= DONE;
          end else begin
            if (beat_q == len_q) err <= 1'b1;
            beat_q <= beat_q + LEN_WTH'(1);
          end
        end
        DONE: begin
          done <= 1'b1; busy <= 1'b0; state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_seq.sv
// Directed bench for axi_burst_seq with a reactive AXI slave and queue scoreboard.
module tb_axi_burst_seq;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic [7:0]  burst_len = '0;
  logic        busy, done, err;
  logic [31:0] cycle_cnt;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  axi_burst_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .busy(busy), .done(done), .err(err),
    .cycle_cnt(cycle_cnt), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] awq[$], arq[$];
  logic [64:0] wq[$];
  logic [63:0] mem [bit [31:0]];
  int  stall = 0, corrupt_beat = -1, rlast_at = -1, r_beats = 0, r_gbeat = 0;
  bit  any_valid = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Slave: decide handshakes at negedge, update drives just after posedge.
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_hold, w_hold, ar_hold, b_pend, r_act;
  logic [40:0] aw_snap, ar_snap;
  logic [65:0] w_snap;
  logic [31:0] w_addr, r_addr, rd_a;
  logic [7:0]  r_len;
  int          aw_wait, w_wait, ar_wait, r_beat;
  initial begin : slave
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0; rdata = '0;
    bid = '0; rid = '0; bresp = '0; rresp = '0;
    aw_hold = 0; w_hold = 0; ar_hold = 0; b_pend = 0; r_act = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; r_beat = 0; w_addr = '0; r_addr = '0; r_len = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        aw_hold = 0; w_hold = 0; ar_hold = 0; b_pend = 0; r_act = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (awvalid || wvalid || arvalid) any_valid = 1;
        aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
        ar_hs = arvalid && arready; r_hs = rvalid && rready;
        if (aw_hold) chk("aw_stable", {awvalid, awaddr, awlen}, aw_snap);
        if (w_hold)  chk("w_stable", {wvalid, wlast, wdata}, w_snap);
        if (ar_hold) chk("ar_stable", {arvalid, araddr, arlen}, ar_snap);
        if (aw_hs) begin
          chk("aw_expected", awq.size() != 0, 1);
          if (awq.size() != 0) chk("awaddr", awaddr, awq.pop_front());
          w_addr = awaddr; aw_wait = 0;
        end
        if (w_hs) begin
          chk("w_expected", wq.size() != 0, 1);
          if (wq.size() != 0) chk("wbeat", {wlast, wdata}, wq.pop_front());
          mem[w_addr] = wdata; w_addr += 32'd8; w_wait = 0;
          if (wlast) b_pend = 1;
        end
        if (b_hs) b_pend = 0;
        if (ar_hs) begin
          chk("ar_expected", arq.size() != 0, 1);
          if (arq.size() != 0) chk("araddr", araddr, arq.pop_front());
          r_addr = araddr; r_len = arlen; r_beat = 0; r_act = 1; ar_wait = 0;
        end
        if (r_hs) begin
          r_beats++; r_gbeat++; r_beat++;
          if (rlast) r_act = 0;
        end
        aw_hold = awvalid && !awready; aw_snap = {1'b1, awaddr, awlen};
        w_hold  = wvalid && !wready;   w_snap  = {1'b1, wlast, wdata};
        ar_hold = arvalid && !arready; ar_snap = {1'b1, araddr, arlen};
      end
      @(posedge clk); #1;
      if (!rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0; rdata = '0;
      end else begin
        aw_wait = awvalid ? aw_wait + 1 : 0;
        w_wait  = wvalid  ? w_wait + 1  : 0;
        ar_wait = arvalid ? ar_wait + 1 : 0;
        awready = (stall == 0) || (aw_wait >= stall);
        wready  = (stall == 0) || (w_wait >= stall);
        arready = (stall == 0) || (ar_wait >= stall);
        bvalid  = b_pend;
        rvalid  = r_act;
        rlast   = r_act && (r_beat == ((rlast_at < 0) ? int'(r_len) : rlast_at));
        rd_a    = r_addr + 32'(r_beat * 8);
        rdata   = (r_gbeat == corrupt_beat) ? 64'hFF : (mem.exists(rd_a) ? mem[rd_a] : 64'h0);
      end
    end
  end

  task automatic run(input logic [1:0] m, input logic [31:0] base, input logic [15:0] nb,
                     input logic [7:0] len, input logic exp_err, input bit poke);
    int p, lat, bcyc;
    bit seen;
    p = 0;
    if (nb != 0 && m != 2'b01)
      for (int b = 0; b < int'(nb); b++) begin
        awq.push_back(base + 32'(b) * ((32'(len) + 32'd1) * 32'd8));
        for (int k = 0; k <= int'(len); k++) begin
          wq.push_back({(k == int'(len)), 64'(p)});
          p++;
        end
      end
    if (nb != 0 && m != 2'b00)
      for (int b = 0; b < int'(nb); b++)
        arq.push_back(base + 32'(b) * ((32'(len) + 32'd1) * 32'd8));
    any_valid = 0;
    @(negedge clk);
    mode = m; base_addr = base; num_bursts = nb; burst_len = len; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_on", busy, 1);
    chk("err_clr", err, 0);
    bcyc = 1; lat = 1; seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (poke) begin
        start     = (c == 3);
        base_addr = (c == 3) ? 32'hDEAD_0000 : base;
      end
      if (busy) bcyc++;
      if (done) seen = 1;
    end
    start = 0;
    chk("done_seen", seen, 1);
    chk("busy_off", busy, 0);
    chk("cycle_cnt", cycle_cnt, bcyc);
    chk("err_final", err, exp_err);
    chk("queues_empty", awq.size() + wq.size() + arq.size(), 0);
    if (nb == 16'd0) begin
      chk("nb0_latency", lat, 2);
      chk("nb0_no_valid", any_valid, 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit seen;
    #1;
    chk("rst_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, busy, done, err}, 0);
    chk("rst_addr", {awaddr, araddr, awlen, arlen}, 0);
    chk("rst_data", {wdata, cycle_cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("idle_after_rst", {busy, done}, 0);

    run(2'b00, 32'h1000, 16'd2, 8'd3, 1'b0, 0);   // write only
    run(2'b10, 32'h1000, 16'd2, 8'd3, 1'b0, 0);   // write then read back
    r_gbeat = 0; corrupt_beat = 2;
    run(2'b01, 32'h1000, 16'd2, 8'd3, 1'b1, 0);   // read with corrupted beat
    corrupt_beat = -1;
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1);
    stall = 5;
    run(2'b10, 32'h2000, 16'd2, 8'd3, 1'b0, 1);   // backpressure + ignored start
    stall = 0;
    run(2'b00, 32'h5000, 16'd0, 8'd3, 1'b0, 0);   // empty phases
    run(2'b11, 32'h4000, 16'd1, 8'd0, 1'b0, 0);   // mode 11, single-beat burst
    run(2'b00, 32'hFFFF_FFF0, 16'd2, 8'd1, 1'b0, 0); // address wrap
    rlast_at = 1; r_beats = 0;
    run(2'b01, 32'h1000, 16'd1, 8'd3, 1'b1, 0);   // early rlast
    chk("early_rlast_beats", r_beats, 2);
    rlast_at = 5; r_beats = 0;
    run(2'b01, 32'h1000, 16'd1, 8'd3, 1'b1, 0);   // late rlast
    chk("late_rlast_beats", r_beats, 6);
    rlast_at = -1;

    // Reset in the middle of write beat 1.
    awq.push_back(32'h3000);
    wq.push_back({1'b0, 64'd0});
    wq.push_back({1'b0, 64'd1});
    @(negedge clk);
    mode = 2'b00; base_addr = 32'h3000; num_bursts = 16'd2; burst_len = 8'd3; start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (wvalid && wdata == 64'd1) seen = 1;
    end
    chk("reach_beat1", seen, 1);
    #2 rst = 0;
    #1;
    chk("midrst_ctrl", {awvalid, wvalid, wlast, bready, arvalid, rready, busy, done, err}, 0);
    chk("midrst_addr", {awaddr, araddr, awlen, arlen}, 0);
    chk("midrst_data", {wdata, cycle_cnt}, 0);
    awq.delete(); wq.delete(); arq.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);
    run(2'b00, 32'h3000, 16'd2, 8'd3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
